mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_pick.sv | 27 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   - FSM state encodings (IDLE / ACCESS)
//   - owner identifiers (FETCH = 0, DATA = 1)
//   - width of the access-cycle and starvation counters
//   - latched access descriptor carried through the ACCESS state
package mem_arbiter_pkg;

  localparam int CNT_W = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        owner;
  } acc_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: combinational choice between the fetch and data requesters.
// Ports:
//   if_req      in  fetch port is requesting
//   d_req       in  data port is requesting
//   starve_sat  in  fetch has lost the maximum allowed number of times in a row
//   pick_valid  out at least one requester is present
//   pick_owner  out winning owner (OWNER_FETCH / OWNER_DATA)
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic starve_sat,
  output logic pick_valid,
  output logic pick_owner
);

  always_comb begin
    pick_valid = if_req | d_req;
    pick_owner = OWNER_FETCH;
    // Data normally wins a tie; a starved fetch takes the tie instead.
    if (d_req && !(if_req && starve_sat)) begin
      pick_owner = OWNER_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between an instruction-fetch
// port and a load/store data port. One access is in flight at a time; it is
// granted in IDLE, held for LATENCY cycles in ACCESS, and its result is
// returned with a one-cycle rvalid pulse on the owner's port.
// Ports:
//   clock, reset                  clock and synchronous active-high reset
//   if_req/if_addr                fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata     fetch accept pulse, result pulse, fetched word
//   d_req/d_we/d_addr/d_wdata     data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata        data accept pulse, result pulse, load word (0 for stores)
//   mem_we/mem_addr/mem_wdata     shared memory controls (all 0 while idle)
//   mem_rdata                     combinational read data from the memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v == lim) ? v : v + CNT_ONE;
  endfunction

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] starve;
  acc_t             acc;

  logic pick_valid;
  logic pick_owner;
  logic starve_sat;
  logic grant;
  logic last_cyc;

  assign starve_sat = (starve == STARVE_C);

  arb_pick u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve_sat (starve_sat),
    .pick_valid (pick_valid),
    .pick_owner (pick_owner)
  );

  // Grant and write enable are gated by reset so that an access caught by
  // reset neither starts nor commits its store.
  assign grant    = !reset && (state == ST_IDLE) && pick_valid;
  assign last_cyc = (state == ST_ACCESS) && (cnt == CNT_ONE);

  assign if_gnt    = grant && (pick_owner == OWNER_FETCH);
  assign d_gnt     = grant && (pick_owner == OWNER_DATA);
  assign mem_addr  = (state == ST_ACCESS) ? acc.addr  : 32'd0;
  assign mem_wdata = (state == ST_ACCESS) ? acc.wdata : 32'd0;
  assign mem_we    = !reset && last_cyc && (acc.owner == OWNER_DATA) && acc.we;

  // Control: FSM, counters, result pulses and returned data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      starve    <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (state == ST_IDLE) begin
        if (grant) begin
          state <= ST_ACCESS;
          cnt   <= LAT_C;
          if (pick_owner == OWNER_FETCH) begin
            starve <= '0;
          end else if (if_req) begin
            starve <= sat_inc(starve, STARVE_C);
          end
        end
      end else begin
        cnt <= cnt - CNT_ONE;
        if (last_cyc) begin
          state <= ST_IDLE;
          if (acc.owner == OWNER_FETCH) begin
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
          end else begin
            d_rdata  <= acc.we ? 32'd0 : mem_rdata;
            d_rvalid <= 1'b1;
          end
        end
      end
    end
  end

  // Access descriptor: captured on grant only, never read outside ACCESS.
  always_ff @(posedge clock) begin
    if (grant) begin
      acc.owner <= pick_owner;
      if (pick_owner == OWNER_DATA) begin
        acc.addr  <= d_addr;
        acc.wdata <= d_wdata;
        acc.we    <= d_we;
      end else begin
        acc.addr  <= if_addr;
        acc.wdata <= 32'd0;
        acc.we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// phase, all compared against a transaction-timeline reference model.
module tb_mem_arbiter;

  localparam int LAT  = 1;
  localparam int SMAX = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  // Second instance with a longer memory latency.
  logic        l3_d_req = 1'b0;
  logic [31:0] l3_d_addr = 32'd0;
  logic        l3_if_gnt, l3_if_rvalid, l3_d_gnt, l3_d_rvalid, l3_mem_we;
  logic [31:0] l3_if_rdata, l3_d_rdata, l3_mem_addr, l3_mem_wdata, l3_mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LATENCY(3), .STARVE_MAX(SMAX)) u_dut_l3 (
    .clock(clock), .reset(reset),
    .if_req(1'b0), .if_addr(32'd0), .if_gnt(l3_if_gnt),
    .if_rvalid(l3_if_rvalid), .if_rdata(l3_if_rdata),
    .d_req(l3_d_req), .d_we(1'b0), .d_addr(l3_d_addr), .d_wdata(32'd0),
    .d_gnt(l3_d_gnt), .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata),
    .mem_we(l3_mem_we), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_rdata(l3_mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'h00500093;
      17:      return 32'h0BADF00D;
      32:      return 32'hCAFEF00D;
      default: return (32'(i) * 32'h9E3779B1) ^ 32'h13579BDF;
    endcase
  endfunction

  // Memory attached to the main instance.
  logic [31:0] phys_mem [0:63];
  bit          mem_loaded = 1'b0;
  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) phys_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      phys_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata    = phys_mem[mem_addr[7:2]];
  assign l3_mem_rdata = init_word(int'(l3_mem_addr[7:2]));

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: each access is a record (grant cycle, owner, address,
  // data). Access cycles are grant+1..grant+LAT, the result is due at
  // grant+LAT+1, and a new grant is possible whenever no access is open.
  bit          model_on = 1'b0;
  bit          ref_ready = 1'b0;
  int          cyc = 0;
  int          g_cyc = -1;
  int          starve = 0;
  logic        g_owner = 1'b0;
  logic        g_we = 1'b0;
  logic [31:0] g_addr = 32'd0, g_wdata = 32'd0, g_data = 32'd0;
  logic [31:0] exp_if_rdata = 32'd0, exp_d_rdata = 32'd0;
  logic [31:0] ref_mem [0:63];

  always @(negedge clock) begin : model
    bit in_acc, last_acc, done, e_if_gnt, e_d_gnt;
    if (model_on) begin
      if (!ref_ready) begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        ref_ready = 1'b1;
      end
      in_acc   = (g_cyc >= 0) && (cyc > g_cyc) && (cyc <= g_cyc + LAT);
      last_acc = (g_cyc >= 0) && (cyc == g_cyc + LAT);
      done     = (g_cyc >= 0) && (cyc == g_cyc + LAT + 1);
      if (done) begin
        if (g_owner) exp_d_rdata = g_data;
        else         exp_if_rdata = g_data;
      end
      chk_eq("m_if_rvalid", 32'(if_rvalid), 32'(done && !g_owner));
      chk_eq("m_d_rvalid",  32'(d_rvalid),  32'(done && g_owner));
      chk_eq("m_if_rdata",  if_rdata, exp_if_rdata);
      chk_eq("m_d_rdata",   d_rdata,  exp_d_rdata);
      chk_eq("m_mem_addr",  mem_addr,  in_acc ? g_addr  : 32'd0);
      chk_eq("m_mem_wdata", mem_wdata, in_acc ? g_wdata : 32'd0);
      chk_eq("m_mem_we",    32'(mem_we), 32'(last_acc && g_we && !reset));
      if (last_acc && !reset) begin
        if (g_we) begin
          ref_mem[g_addr[7:2]] = g_wdata;
          g_data = 32'd0;
        end else begin
          g_data = ref_mem[g_addr[7:2]];
        end
      end
      e_if_gnt = 1'b0;
      e_d_gnt  = 1'b0;
      if (!reset && !in_acc && (if_req || d_req)) begin
        if (d_req && !(if_req && starve == SMAX)) begin
          e_d_gnt = 1'b1;
          g_owner = 1'b1; g_addr = d_addr; g_wdata = d_wdata; g_we = d_we;
          if (if_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
        end else begin
          e_if_gnt = 1'b1;
          g_owner = 1'b0; g_addr = if_addr; g_wdata = 32'd0; g_we = 1'b0;
          starve = 0;
        end
        g_cyc = cyc;
      end
      chk_eq("m_if_gnt", 32'(if_gnt), 32'(e_if_gnt));
      chk_eq("m_d_gnt",  32'(d_gnt),  32'(e_d_gnt));
      if (reset) begin
        g_cyc = -1;
        starve = 0;
        exp_if_rdata = 32'd0;
        exp_d_rdata = 32'd0;
      end
    end
    cyc++;
  end

  initial begin
    int   ng;
    int   last_k;
    logic seen_if, seen_d;

    @(posedge clock); #1;
    model_on = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk_eq("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk_eq("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk_eq("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk_eq("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk_eq("rst_mem_we", 32'(mem_we), 32'd0);
    chk_eq("rst_mem_addr", mem_addr, 32'd0);
    chk_eq("rst_if_rdata", if_rdata, 32'd0);
    chk_eq("rst_d_rdata", d_rdata, 32'd0);
    tick();

    // Lone fetch of 0x10
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clock);
    chk_eq("fetch_gnt", 32'(if_gnt), 32'd1);
    chk_eq("fetch_no_dgnt", 32'(d_gnt), 32'd0);
    tick();
    if_req = 1'b0;
    @(negedge clock);
    chk_eq("fetch_addr", mem_addr, 32'h10);
    chk_eq("fetch_rv_early", 32'(if_rvalid), 32'd0);
    tick();
    @(negedge clock);
    chk_eq("fetch_rvalid", 32'(if_rvalid), 32'd1);
    chk_eq("fetch_rdata", if_rdata, 32'h00500093);
    tick();

    // Store 0xDEADBEEF to 0x40, then load it back (issued back-to-back)
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    @(negedge clock);
    chk_eq("st_gnt", 32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0;
    @(negedge clock);
    chk_eq("st_we", 32'(mem_we), 32'd1);
    chk_eq("st_addr", mem_addr, 32'h40);
    chk_eq("st_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    d_req = 1'b1; d_we = 1'b0; d_wdata = 32'd0;
    @(negedge clock);
    chk_eq("st_we_off", 32'(mem_we), 32'd0);
    chk_eq("st_rvalid", 32'(d_rvalid), 32'd1);
    chk_eq("st_rdata", d_rdata, 32'd0);
    chk_eq("ld_gnt_b2b", 32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0;
    @(negedge clock);
    tick();
    @(negedge clock);
    chk_eq("ld_rvalid", 32'(d_rvalid), 32'd1);
    chk_eq("ld_rdata", d_rdata, 32'hDEADBEEF);
    tick();

    // Both ports requesting continuously: D D D F D D D F, no idle gap
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
    ng = 0;
    last_k = -1;
    for (int k = 0; k < 40 && ng < 8; k++) begin
      @(negedge clock);
      if (if_gnt || d_gnt) begin
        chk_eq("arb_order", 32'(d_gnt), 32'((ng % 4) != 3));
        if (ng > 0) chk_eq("arb_gap", 32'(k - last_k), 32'(LAT + 1));
        last_k = k;
        ng++;
      end
      tick();
    end
    chk_eq("arb_count", 32'(ng), 32'd8);
    if_req = 1'b0; d_req = 1'b0;
    tick();
    tick();

    // Reset during the access cycle of a store to 0x44
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h12345678;
    @(negedge clock);
    chk_eq("rst_st_gnt", 32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk_eq("rst_st_we", 32'(mem_we), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk_eq("rst_st_rvalid", 32'(d_rvalid), 32'd0);
    chk_eq("rst_st_mem_we", 32'(mem_we), 32'd0);
    chk_eq("rst_st_mem_addr", mem_addr, 32'd0);
    chk_eq("rst_st_mem_wdata", mem_wdata, 32'd0);
    chk_eq("rst_st_d_rdata", d_rdata, 32'd0);
    chk_eq("rst_st_if_rdata", if_rdata, 32'd0);
    tick();
    @(negedge clock);
    chk_eq("rst_st_rvalid2", 32'(d_rvalid), 32'd0);
    chk_eq("rst_st_word", phys_mem[17], 32'h0BADF00D);
    tick();

    // LATENCY=3 load of 0x80
    l3_d_req = 1'b1; l3_d_addr = 32'h80;
    @(negedge clock);
    chk_eq("l3_gnt", 32'(l3_d_gnt), 32'd1);
    tick();
    l3_d_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      chk_eq("l3_addr", l3_mem_addr, 32'h80);
      chk_eq("l3_rv_early", 32'(l3_d_rvalid), 32'd0);
      tick();
    end
    @(negedge clock);
    chk_eq("l3_rvalid", 32'(l3_d_rvalid), 32'd1);
    chk_eq("l3_rdata", l3_d_rdata, 32'hCAFEF00D);
    chk_eq("l3_addr_idle", l3_mem_addr, 32'd0);
    tick();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      seen_if = if_gnt;
      seen_d  = d_gnt;
      tick();
      reset = ($urandom_range(0, 199) == 0);
      if (!if_req || seen_if) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!d_req || seen_d) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        d_wdata = $urandom;
      end
    end
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
    repeat (LAT + 3) tick();

    for (int i = 0; i < 64; i++) chk_eq("mem_final", phys_mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
